div4_seq: RTL and testbench
===========================

// Module: div4_seq
// PURPOSE
//   Sequential restoring divider: unsigned N-bit dividend / N-bit divisor -> quotient + remainder.
//   One quotient bit per cycle via trial subtraction, the inverse of the ripple-carry adder path.
//   Sits beside the ALU adder as a multi-cycle unit with a start/busy/done handshake.
// PARAMETERS
//   N  4  operand width (dividend, divisor, quotient, remainder); N >= 2
// PORTS
//   clk    in   1  single clock, rising edge
//   rst_n  in   1  asynchronous, active-low reset
//   start  in   1  request; sampled only when busy=0
//   A      in   N  dividend, captured with start
//   B      in   N  divisor, captured with start
//   Q      out  N  quotient; valid from done, held until the next accepted start
//   R      out  N  remainder; valid from done, held until the next accepted start
//   busy   out  1  high while in RUN
//   done   out  1  one-cycle pulse when Q/R become valid
//   dz     out  1  divide-by-zero flag, valid with done (see CONFIGURATION)
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; Q, R, busy, done, dz = 0; internal regs and counter = 0.
//   States: IDLE, RUN, DONE.
//   - IDLE: start=1 -> capture A into the Q shift reg and B into the divisor reg; clear the partial remainder; cnt=N; go to RUN.
//   - RUN: each cycle, shift {rem,q} left 1; trial = {1'b0,rem} - {1'b0,B} (N+1 bits).
//     No borrow -> rem=trial[N-1:0], q[0]=1. Borrow -> rem unchanged, q[0]=0. Decrement cnt.
//     cnt reaches 0 -> go to DONE.
//   - DONE: done=1 for exactly this cycle; Q, R updated.
//     start=1 -> accept (as IDLE) and go to RUN. Otherwise go to IDLE.
//   Latency: start accepted at edge t -> done high in cycle t+N+1; back-to-back throughput N+1 cycles.
//   busy = (state==RUN). The start pin is ignored while busy; A and B may change freely during RUN.
//   Visible Q/R change only on entry to DONE, never mid-operation.
//   B=0 without the macro: the algorithm naturally yields Q=all ones, R=A in N+1 cycles.
//   A < B: Q=0, R=A. A=0: Q=0, R=0.
//   Reset asserted mid-RUN: abort immediately, no done pulse; outputs return to 0.
//   Subtraction is full N+1-bit width; the borrow is the trial MSB. No overflow is possible.
// CONFIGURATION
//   Macro DIV4_ZERO_DETECT_EN:
//   - Defined: B==0 at start -> skip RUN; go directly to DONE at the next edge (done at t+1).
//     Q={N{1'b1}}, R=A, dz=1 for the done cycle, then dz holds until the next accepted start.
//   - Undefined: no shortcut; B=0 runs the full N cycles with the natural result above.
//     dz is tied to 0.
// STRUCTURE
//   Shared package div_pkg: state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and counter width clog2(N+1).
//   Sub-module sub_n (parameter N+1): ripple subtractor built from fa cells.
//   - B is inverted and c_in=1; outputs the difference and borrow = ~c_out.
//   - Instantiated once in RUN.
//   All else (FSM, shift regs, counter) lives in div4_seq.
// TESTING
//   13/3: start 1 cycle -> done at t+5, Q=4, R=1, dz=0; busy high for exactly 4 cycles.
//   15/1 -> Q=15, R=0; 0/5 -> Q=0, R=0; 2/9 -> Q=0, R=2.
//   7/0 -> macro on: done at t+1, Q=15, R=7, dz=1; macro off: done at t+5, Q=15, R=7, dz=0.
//   Assert start and change A/B every cycle during RUN -> ignored; the result matches the first operands.
//   start held high across DONE with 9/2 then 10/3 -> second op accepted in the DONE cycle; done pulses 5 cycles apart.
//   rst_n low 2 cycles mid-RUN -> all outputs 0, no done pulse; a new 6/4 afterwards -> Q=1, R=2.
//   Random: all 256 pairs for N=4 against A/B and A%B.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM encodings and counter sizing.
// The optional divide-by-zero shortcut is selected by DIV4_ZERO_DETECT_EN in div4_seq.
package div_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Counter must hold the value n (bit steps remaining at the start of RUN).
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/div4_seq_sub_n.sv
// Ripple subtractor (a - b) built from full-adder cells: b inverted, carry-in 1.
// borrow is the inverted carry out of the top cell.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module sub_n #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);
  logic [W:0] c;

  assign c[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_bit
    fa u_fa (
      .a  (a[i]),
      .b  (~b[i]),
      .ci (c[i]),
      .s  (diff[i]),
      .co (c[i+1])
    );
  end

  assign borrow = ~c[W];
endmodule

// File: rtl/div4_seq.sv
// Sequential restoring divider, one quotient bit per clock, start/busy/done handshake.
// Optional feature: define DIV4_ZERO_DETECT_EN to finish B==0 requests in one cycle with dz set.
module div4_seq
  import div_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         busy,
  output logic         done,
  output logic         dz
);

  localparam int CW = cnt_width(N);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  rem;
  logic [N-1:0]  qsh;
  logic [N-1:0]  dvs;
  logic [N-1:0]  q_r;
  logic [N-1:0]  r_r;
  logic          dz_r;

  logic [N:0]    trial_a;
  logic [N:0]    diff;
  logic          borrow;
  logic [N-1:0]  rem_nxt;
  logic [N-1:0]  q_nxt;
  logic          zero_op;
  logic          unused_msb;

  // The shifted partial remainder needs N+1 bits because it can reach 2*B-1.
  assign trial_a = {rem, qsh[N-1]};

  sub_n #(.W(N + 1)) u_sub (
    .a      (trial_a),
    .b      ({1'b0, dvs}),
    .diff   (diff),
    .borrow (borrow)
  );

  // A successful subtraction always leaves a value below B, so the top bit is zero.
  assign unused_msb = diff[N];
  assign rem_nxt    = borrow ? trial_a[N-1:0] : diff[N-1:0];
  assign q_nxt      = {qsh[N-2:0], ~borrow};

`ifdef DIV4_ZERO_DETECT_EN
  assign zero_op = (B == '0);
`else
  assign zero_op = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      rem   <= '0;
      qsh   <= '0;
      dvs   <= '0;
      q_r   <= '0;
      r_r   <= '0;
      dz_r  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start && zero_op) begin
            q_r   <= '1;
            r_r   <= A;
            dz_r  <= 1'b1;
            state <= DONE;
          end else if (start) begin
            qsh   <= A;
            dvs   <= B;
            rem   <= '0;
            cnt   <= CW'(N);
            dz_r  <= 1'b0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          rem <= rem_nxt;
          qsh <= q_nxt;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            q_r   <= q_nxt;
            r_r   <= rem_nxt;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Q    = q_r;
  assign R    = r_r;
  assign dz   = dz_r;
  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_div4_seq.sv
// Directed and exhaustive bench for div4_seq (N=4); expectations follow DIV4_ZERO_DETECT_EN.
module tb_div4_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a_in;
  logic [3:0] b_in;
  logic [3:0] q_o;
  logic [3:0] r_o;
  logic       busy_o;
  logic       done_o;
  logic       dz_o;

  int n_chk  = 0;
  int n_pass = 0;

  int res_q, res_r, res_dz, res_lat, res_busy;

`ifdef DIV4_ZERO_DETECT_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif

  div4_seq #(.N(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (a_in),
    .B     (b_in),
    .Q     (q_o),
    .R     (r_o),
    .busy  (busy_o),
    .done  (done_o),
    .dz    (dz_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
  endtask

  // Latency counts clock edges from the accepting edge (inclusive) to the first sample with done high.
  task automatic do_op(input int a, input int b, input bit noise);
    a_in  = 4'(a);
    b_in  = 4'(b);
    start = 1'b1;
    @(posedge clk); #1;
    res_lat  = 1;
    res_busy = 0;
    while (!done_o && res_lat < 20) begin
      if (busy_o) res_busy++;
      if (noise) begin
        start = 1'b1;
        a_in  = 4'($urandom_range(15));
        b_in  = 4'($urandom_range(15));
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      res_lat++;
    end
    start  = 1'b0;
    res_q  = int'(q_o);
    res_r  = int'(r_o);
    res_dz = int'(dz_o);
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc;
    bit seen;
    int eq, er, el, ed;

    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_q", int'(q_o), 0);
    check("rst_r", int'(r_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_dz", int'(dz_o), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(13, 3, 1'b0);
    check("13/3 q", res_q, 4);
    check("13/3 r", res_r, 1);
    check("13/3 dz", res_dz, 0);
    check("13/3 lat", res_lat, 5);
    check("13/3 busy_cycles", res_busy, 4);

    do_op(15, 1, 1'b0);
    check("15/1 q", res_q, 15);
    check("15/1 r", res_r, 0);
    do_op(0, 5, 1'b0);
    check("0/5 q", res_q, 0);
    check("0/5 r", res_r, 0);
    do_op(2, 9, 1'b0);
    check("2/9 q", res_q, 0);
    check("2/9 r", res_r, 2);

    do_op(7, 0, 1'b0);
    check("7/0 q", res_q, 15);
    check("7/0 r", res_r, 7);
    check("7/0 dz", res_dz, ZD ? 1 : 0);
    check("7/0 lat", res_lat, ZD ? 1 : 5);
    check("7/0 dz_hold", int'(dz_o), ZD ? 1 : 0);

    // Operand and start noise during RUN must not disturb the captured 11/3.
    do_op(11, 3, 1'b1);
    check("noise q", res_q, 3);
    check("noise r", res_r, 2);

    // start held through DONE: second request accepted in the DONE cycle.
    a_in  = 4'd9;
    b_in  = 4'd2;
    start = 1'b1;
    @(posedge clk); #1;
    a_in = 4'd10;
    b_in = 4'd3;
    cyc  = 1;
    while (!done_o && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("b2b first lat", cyc, 5);
    check("b2b 9/2 q", int'(q_o), 4);
    check("b2b 9/2 r", int'(r_o), 1);
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 1;
    while (!done_o && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("b2b gap", cyc, 5);
    check("b2b 10/3 q", int'(q_o), 3);
    check("b2b 10/3 r", int'(r_o), 1);
    @(posedge clk); #1;

    // Reset mid-RUN aborts with no done pulse.
    a_in  = 4'd13;
    b_in  = 4'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort q", int'(q_o), 0);
    check("abort r", int'(r_o), 0);
    check("abort busy", int'(busy_o), 0);
    check("abort done", int'(done_o), 0);
    check("abort dz", int'(dz_o), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done_o) seen = 1'b1;
    end
    check("abort no_done", int'(seen), 0);
    check("abort idle_busy", int'(busy_o), 0);
    do_op(6, 4, 1'b0);
    check("6/4 q", res_q, 1);
    check("6/4 r", res_r, 2);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        eq = (b == 0) ? 15 : a / b;
        er = (b == 0) ? a : a % b;
        el = (ZD && b == 0) ? 1 : 5;
        ed = (ZD && b == 0) ? 1 : 0;
        do_op(a, b, 1'b0);
        check($sformatf("q %0d/%0d", a, b), res_q, eq);
        check($sformatf("r %0d/%0d", a, b), res_r, er);
        check($sformatf("lat %0d/%0d", a, b), res_lat, el);
        check($sformatf("dz %0d/%0d", a, b), res_dz, ed);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
